fir_out_decim_sat: RTL and testbench
====================================

Name: fir_out_decim_sat

Overview:
Output stage directly downstream of the 100-tap direct-form FIR, which produces one 32-bit signed result per clock with Q15 coefficients.
- Requantises each FIR result to OUT_W bits: round, then saturate.
- Discards the filter warm-up samples.
- Decimates by DECIM.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the next consumer.
- The FIR cannot stall, so there is no backpressure to it; overflow is flagged instead.

Parameters:
IN_W, 32, FIR output width
OUT_W, 16, output sample width
SHIFT, 15, right shift for coefficient scaling (Q15); must be >= 1
DECIM, 2, decimation factor; must be >= 1; 1 = no decimation
WARMUP, 100, number of accepted samples discarded after reset (equals tap count)
FIFO_DEPTH, 8, output FIFO entries; must be a power of 2, >= 2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  y_in carries a valid FIR result this cycle
y_in  in  IN_W  signed FIR result
out_data  out  OUT_W  signed requantised sample at FIFO head; 0 when out_valid=0
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data this cycle
fill_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
sat_flag  out  1  sticky: a kept sample saturated
ovf_flag  out  1  sticky: a kept sample was dropped because the FIFO was full
clear_flags  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset: all pipeline regs, counters and pointers go to 0; FIFO is empty; all outputs are 0; the warm-up count restarts. This applies equally to reset asserted mid-operation; stored data is lost.
- Rounding: r = (sext(y_in, IN_W+1) + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits. This is round-half-up and must not wrap at the positive extreme.
- Saturation: clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. A clamped sample sets sat_flag only if the sample is kept.
- Warm-up counter: counts accepted samples (in_valid=1) from 0 to WARMUP, then holds. A sample is "post-warm-up" when the counter already equals WARMUP at acceptance, so the first WARMUP samples are dropped.
- Decimation phase counter: 0..DECIM-1, advances on each post-warm-up accepted sample and wraps to 0. A sample is kept when phase==0, so post-warm-up samples 0, DECIM, 2·DECIM, ... are kept.
- Stage 1 register captures the rounded/saturated value plus a keep bit.
- Stage 2 writes to the FIFO on the next edge.
- Latency: a sample accepted at edge k is visible with out_valid=1 after edge k+1, i.e. a 2-cycle latency when the FIFO is empty.
- Handshake:
  - A read occurs on an edge where out_valid & out_ready.
  - out_data and out_valid stay stable until read.
  - out_data comes from the registered head entry.
- FIFO full with a write pending:
  - If a read occurs on the same edge, the write is accepted and occupancy is unchanged.
  - Otherwise the new sample is dropped, the FIFO contents are unchanged, and ovf_flag sets.
- Empty FIFO: a read is impossible; out_ready is ignored.
- Pointers wrap modulo FIFO_DEPTH; fill_level ranges 0..FIFO_DEPTH.
- clear_flags: clears the flags on the next edge. If a set event occurs on the same edge, the set wins and the flag reads 1.

Decomposition:
- Shared package fir_pkg holds:
  - IN_W, OUT_W, SHIFT defaults;
  - OUT_MAX/OUT_MIN saturation constants;
  - a rounding/saturating function.
- One sub-module, fir_sync_fifo (parameters WIDTH, DEPTH), providing push, pop, full, empty and count.
- Warm-up/decimation counters and the requantiser stay in the top level.

Test Plan:
- Reset, then 100 samples of y_in=32768 with out_ready=1 → no out_valid. 101st and 102nd samples y_in=32768 → exactly one output, out_data=1, out_valid first high 2 cycles after the 101st accept; 103rd sample → second output.
- Rounding, post-warm-up, DECIM=1 build: y_in=16384 → 1; 16383 → 0; -16384 → 0; -16385 → -1; 49151 → 1; 49152 → 2; sat_flag stays 0.
- Saturation: y_in=32'h7FFFFFFF → 32767; y_in=32'h80000000 → -32768; sat_flag=1 after the first. Asserting clear_flags with no concurrent saturation → 0 next cycle. clear_flags on the same cycle as a saturating kept sample → sat_flag stays 1.
- Overflow, DECIM=2, out_ready=0, 18 post-warm-up samples with values 1..18 (×32768) → 9 kept (1,3,...,17); fill_level=8; ovf_flag=1. Draining yields 1,3,5,...,15 in order; 17 is lost.
- Full + simultaneous read/write: FIFO full, out_ready=1 in the same cycle a kept sample arrives → fill_level stays 8, ovf_flag stays 0, the new sample appears last in the drain order.
- Reset mid-operation: FIFO holding 5 entries, warm-up done, reset pulsed → out_valid=0, fill_level=0, flags 0. The next 100 samples are discarded again.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths, saturation limits and the round-then-saturate helper for the FIR output stage.
// Pure constants and a combinational function; no latency, no flow control.
package fir_pkg;

    localparam int DEF_IN_W  = 32;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 15;

    localparam logic signed [DEF_OUT_W-1:0] OUT_MAX = {1'b0, {(DEF_OUT_W-1){1'b1}}};
    localparam logic signed [DEF_OUT_W-1:0] OUT_MIN = {1'b1, {(DEF_OUT_W-1){1'b0}}};

    // Evaluated at 64 bits so the +half bias can never wrap for any input up to 62 bits wide.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] x,
        input  int                 shift,
        input  int                 out_w,
        output logic               sat
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r   = (x + (64'sd1 <<< (shift - 1))) >>> shift;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        sat = 1'b0;
        if (r > hi) begin
            round_sat = hi;
            sat       = 1'b1;
        end else if (r < lo) begin
            round_sat = lo;
            sat       = 1'b1;
        end else begin
            round_sat = r;
        end
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Registered-memory synchronous FIFO; read data is the head entry, visible the cycle after the write.
// A push while full is accepted only when a pop happens on the same edge, otherwise it is ignored.
module fir_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdat_o  = mem_q[rd_ptr_q];

    assign rd_en = pop_i & ~empty_o;
    assign wr_en = push_i & (~full_o | rd_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= wdat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_decim_sat.sv
// FIR output stage: round/saturate, drop warm-up, decimate, buffer onto a valid/ready port.
// Two cycles input-to-out_valid when empty; upstream cannot stall, so a full FIFO drops and sets ovf_flag.
module fir_out_decim_sat
    import fir_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SHIFT      = DEF_SHIFT,
    parameter int DECIM      = 2,
    parameter int WARMUP     = 100,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic signed [IN_W-1:0]        y_in,
    output logic signed [OUT_W-1:0]       out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          sat_flag,
    output logic                          ovf_flag,
    input  logic                          clear_flags
);

    localparam int WC_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [WC_W-1:0]  warm_q, warm_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             s1_vld_q, s1_vld_d;
    logic [OUT_W-1:0] s1_dat_q, s1_dat_d;
    logic             sat_q, sat_d;
    logic             ovf_q, ovf_d;

    logic             post_warm;
    logic             keep;
    logic             sat_c;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_W-1:0] fifo_rdat;

    assign post_warm = (warm_q == WC_W'(WARMUP));
    assign keep      = in_valid & post_warm & (phase_q == '0);
    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;

    always_comb begin
        warm_d   = warm_q;
        phase_d  = phase_q;
        s1_vld_d = keep;
        sat_c    = 1'b0;
        s1_dat_d = OUT_W'(round_sat(64'(y_in), SHIFT, OUT_W, sat_c));
        if (in_valid) begin
            if (!post_warm) begin
                warm_d = warm_q + 1'b1;
            end else if (phase_q == PH_W'(DECIM - 1)) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
        // A set on the same edge as clear_flags wins.
        sat_d = (sat_q & ~clear_flags) | (keep & sat_c);
        ovf_d = (ovf_q & ~clear_flags) | (s1_vld_q & fifo_full & ~pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_q   <= '0;
            phase_q  <= '0;
            s1_vld_q <= 1'b0;
            s1_dat_q <= '0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            warm_q   <= warm_d;
            phase_q  <= phase_d;
            s1_vld_q <= s1_vld_d;
            s1_dat_q <= s1_dat_d;
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (s1_vld_q),
        .wdat_i  (s1_dat_q),
        .pop_i   (pop),
        .rdat_o  (fifo_rdat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fill_level)
    );

    assign out_data = out_valid ? fifo_rdat : '0;
    assign sat_flag = sat_q;
    assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_fir_out_decim_sat.sv
// Directed bench for fir_out_decim_sat with default parameters (DECIM=2, WARMUP=100, depth 8).
module tb_fir_out_decim_sat;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic signed [31:0] y_in;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         fill_level;
    logic               sat_flag;
    logic               ovf_flag;
    logic               clear_flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_out_decim_sat dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .y_in        (y_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill_level  (fill_level),
        .sat_flag    (sat_flag),
        .ovf_flag    (ovf_flag),
        .clear_flags (clear_flags)
    );

    typedef struct {
        logic signed [31:0] y;
        int                 exp;
        logic               exp_sat;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic pop_check(input int exp, input string name);
        @(negedge clk);
        chk({name, "_vld"}, out_valid, 1);
        chk({name, "_dat"}, out_data, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Sends samples k*32768 for k = 1..n back to back, then idles two cycles.
    task automatic burst(input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            y_in     = k * 32768;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Assumes warm-up and phase counters at 0; leaves phase at 0 and FIFO empty.
    task automatic warm_test(input string tag);
        int early = 0;
        for (int i = 1; i <= 105; i++) begin
            @(negedge clk);
            if (i <= 102 && out_valid) early++;
            if (i == 103) begin
                chk({tag, "_vld103"}, out_valid, 1);
                chk({tag, "_dat103"}, out_data, 1);
                chk({tag, "_fill103"}, fill_level, 1);
            end
            if (i == 104) chk({tag, "_fill104"}, fill_level, 1);
            if (i == 105) chk({tag, "_fill105"}, fill_level, 2);
            out_ready = (i <= 100);
            in_valid  = (i <= 103);
            y_in      = 32768;
        end
        chk({tag, "_early_valid"}, early, 0);
        pop_check(1, {tag, "_pop0"});
        pop_check(1, {tag, "_pop1"});
        @(negedge clk);
        chk({tag, "_empty"}, out_valid, 0);
        in_valid = 1'b1;
        y_in     = 0;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'sd16384, 1, 1'b0};
        tbl[1] = '{32'sd16383, 0, 1'b0};
        tbl[2] = '{-32'sd16384, 0, 1'b0};
        tbl[3] = '{-32'sd16385, -1, 1'b0};
        tbl[4] = '{32'sd49151, 1, 1'b0};
        tbl[5] = '{32'sd49152, 2, 1'b0};
        tbl[6] = '{32'sh3FFF8000, 32767, 1'b0};
        tbl[7] = '{32'shC0000000, -32768, 1'b0};
        tbl[8] = '{32'sh7FFFFFFF, 32767, 1'b1};
        tbl[9] = '{32'sh80000000, -32768, 1'b1};

        reset       = 1'b1;
        in_valid    = 1'b0;
        y_in        = '0;
        out_ready   = 1'b0;
        clear_flags = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_vld", out_valid, 0);
        chk("rst_dat", out_data, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_ovf", ovf_flag, 0);
        reset = 1'b0;

        warm_test("warm");

        // Each vector is followed by a phase-1 sample that decimation discards.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            y_in     = tbl[i].y;
            @(negedge clk);
            y_in = 0;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_vld", i), out_valid, 1);
            chk($sformatf("vec%0d_dat", i), out_data, tbl[i].exp);
            chk($sformatf("vec%0d_sat", i), sat_flag, tbl[i].exp_sat);
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end

        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("clr_sat", sat_flag, 0);

        @(negedge clk);
        in_valid    = 1'b1;
        y_in        = 32'sh7FFFFFFF;
        clear_flags = 1'b1;
        @(negedge clk);
        y_in        = 0;
        clear_flags = 1'b0;
        chk("clr_vs_set_sat", sat_flag, 1);
        @(negedge clk);
        in_valid = 1'b0;
        pop_check(32767, "clr_vs_set_pop");

        burst(18);
        chk("ovf_fill", fill_level, 8);
        chk("ovf_flag", ovf_flag, 1);
        for (int k = 1; k <= 15; k += 2) pop_check(k, $sformatf("ovf_drain%0d", k));
        @(negedge clk);
        chk("ovf_empty", out_valid, 0);
        chk("ovf_fill0", fill_level, 0);

        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("clr_ovf", ovf_flag, 0);
        chk("clr_sat2", sat_flag, 0);

        burst(16);
        chk("fs_fill_pre", fill_level, 8);
        in_valid = 1'b1;
        y_in     = 17 * 32768;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("fs_fill", fill_level, 8);
        chk("fs_ovf", ovf_flag, 0);
        for (int k = 3; k <= 17; k += 2) pop_check(k, $sformatf("fs_drain%0d", k));
        @(negedge clk);
        chk("fs_empty", out_valid, 0);

        // Realign phase, then load 5 entries including a saturated one.
        in_valid = 1'b1;
        y_in     = 0;
        @(negedge clk);
        y_in = 32'sh7FFFFFFF;
        burst(9);
        @(negedge clk);
        chk("mid_fill", fill_level, 5);
        chk("mid_sat", sat_flag, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_dat", out_data, 0);
        chk("mid_rst_fill", fill_level, 0);
        chk("mid_rst_sat", sat_flag, 0);
        chk("mid_rst_ovf", ovf_flag, 0);
        reset = 1'b0;

        warm_test("rewarm");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
